pe_mac_sequencer: RTL and testbench

Controller that sequences one PE (registered unsigned multiplier, ifm × wgt → product) through a convolution window of num_taps operand pairs. It accepts streamed ifm/wgt pairs over a valid/ready handshake and drives them into the PE. It tracks the PE's pipeline latency and accumulates the returned products. The finished window sum is presented on a valid/ready output. It sits between the operand buffers and the PE array row, one instance per PE column.

---
 rtl/cnn_pkg.sv | 22 ++
 rtl/pe_valid_pipe.sv | 28 ++
 rtl/pe_mac_sequencer.sv | 124 ++++++++++++
 tb/tb_pe_mac_sequencer.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/cnn_pkg.sv
// Shared types and defaults for the PE MAC sequencer.
package cnn_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FEED   = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_OUTPUT = 2'd3
    } state_e;

    localparam int DEF_INPUT_WIDTH  = 8;
    localparam int DEF_OUTPUT_WIDTH = 16;
    localparam int DEF_ACC_WIDTH    = 20;
    localparam int DEF_MAX_TAPS     = 9;
    localparam int DEF_PE_LAT       = 1;

    // Bits needed to hold a tap count in 0..max_taps.
    function automatic int tap_w(input int max_taps);
        return $clog2(max_taps + 1);
    endfunction

endpackage

// File: rtl/pe_valid_pipe.sv
// Delay line tracking which PE cycles carry a real operand pair.
module pe_valid_pipe #(
    parameter int DEPTH = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic issue,
    output logic last,
    output logic any
);

    logic [DEPTH-1:0] vld_pipe_q, vld_pipe_d;

    // Shift the issue flag in at bit 0 every cycle.
    always_comb begin
        vld_pipe_d = (vld_pipe_q << 1) | DEPTH'(issue);
    end

    // Pipe register, cleared on reset.
    always_ff @(posedge clk) begin
        if (rst) vld_pipe_q <= '0;
        else     vld_pipe_q <= vld_pipe_d;
    end

    assign last = vld_pipe_q[DEPTH-1];
    assign any  = |vld_pipe_q;

endmodule

// File: rtl/pe_mac_sequencer.sv
// Feeds one PE with a window of operand pairs and accumulates its products.
module pe_mac_sequencer
    import cnn_pkg::*;
#(
    parameter int INPUT_WIDTH  = DEF_INPUT_WIDTH,
    parameter int OUTPUT_WIDTH = DEF_OUTPUT_WIDTH,
    parameter int ACC_WIDTH    = DEF_ACC_WIDTH,
    parameter int MAX_TAPS     = DEF_MAX_TAPS,
    parameter int PE_LAT       = DEF_PE_LAT
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic [tap_w(MAX_TAPS)-1:0]    num_taps,
    output logic                          busy,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [INPUT_WIDTH-1:0]        in_ifm,
    input  logic [INPUT_WIDTH-1:0]        in_wgt,
    output logic [INPUT_WIDTH-1:0]        pe_ifm,
    output logic [INPUT_WIDTH-1:0]        pe_wgt,
    input  logic [OUTPUT_WIDTH-1:0]       pe_product,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [ACC_WIDTH-1:0]          out_data
);

    localparam int              TW         = tap_w(MAX_TAPS);
    localparam logic [TW-1:0]   MAX_TAPS_C = TW'(MAX_TAPS);

    state_e                  state_q, state_d;
    logic [TW-1:0]           taps_q, taps_d, cnt_q, cnt_d, cnt_inc, taps_clamped;
    logic [ACC_WIDTH-1:0]    acc_q, acc_d, out_data_q, out_data_d;
    logic [INPUT_WIDTH-1:0]  pe_ifm_q, pe_ifm_d, pe_wgt_q, pe_wgt_d;
    logic                    in_fire, out_fire, pipe_last, pipe_any;

    assign in_fire      = in_valid & in_ready;
    assign out_fire     = out_valid & out_ready;
    assign cnt_inc      = cnt_q + TW'(1);
    assign taps_clamped = (num_taps > MAX_TAPS_C) ? MAX_TAPS_C : num_taps;

    // Marks PE cycles holding real pairs; the last stage lines up with pe_product.
    pe_valid_pipe #(.DEPTH(PE_LAT + 1)) u_vld_pipe (
        .clk   (clk),
        .rst   (rst),
        .issue (in_fire),
        .last  (pipe_last),
        .any   (pipe_any)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (start) state_d = (taps_clamped == '0) ? ST_OUTPUT : ST_FEED;
            ST_FEED:   if (in_fire && cnt_inc == taps_q) state_d = ST_DRAIN;
            ST_DRAIN:  if (!pipe_any) state_d = ST_OUTPUT;
            ST_OUTPUT: if (out_ready) state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Handshake and status outputs decoded from state.
    always_comb begin
        busy      = (state_q != ST_IDLE);
        in_ready  = (state_q == ST_FEED);
        out_valid = (state_q == ST_OUTPUT);
    end

    // Datapath: operand issue, tap count, accumulation and result capture.
    always_comb begin
        taps_d     = taps_q;
        cnt_d      = cnt_q;
        acc_d      = acc_q;
        out_data_d = out_data_q;
        pe_ifm_d   = '0;
        pe_wgt_d   = '0;
        if (pipe_last) acc_d = acc_q + ACC_WIDTH'(pe_product);
        if (state_q == ST_IDLE && start) begin
            taps_d = taps_clamped;
            cnt_d  = '0;
            acc_d  = '0;
            if (taps_clamped == '0) out_data_d = '0;
        end
        if (in_fire) begin
            pe_ifm_d = in_ifm;
            pe_wgt_d = in_wgt;
            cnt_d    = cnt_inc;
        end
        // Pipe empty in DRAIN means the final product is already in acc_q.
        if (state_q == ST_DRAIN && !pipe_any) out_data_d = acc_q;
        if (out_fire) acc_d = '0;
    end

    // Datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            taps_q     <= '0;
            cnt_q      <= '0;
            acc_q      <= '0;
            out_data_q <= '0;
            pe_ifm_q   <= '0;
            pe_wgt_q   <= '0;
        end else begin
            taps_q     <= taps_d;
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            out_data_q <= out_data_d;
            pe_ifm_q   <= pe_ifm_d;
            pe_wgt_q   <= pe_wgt_d;
        end
    end

    assign pe_ifm   = pe_ifm_q;
    assign pe_wgt   = pe_wgt_q;
    assign out_data = out_data_q;

endmodule

// File: tb/tb_pe_mac_sequencer.sv
// Self-checking bench for pe_mac_sequencer with a registered-multiplier PE model.
module tb_pe_mac_sequencer;

    logic        clk = 1'b0;
    logic        rst, start, in_valid, out_ready, busy, in_ready, out_valid;
    logic [3:0]  num_taps;
    logic [7:0]  in_ifm, in_wgt, pe_ifm, pe_wgt;
    logic [15:0] pe_product;
    logic [19:0] out_data;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int last_acc = 0;
    logic [19:0] exp_q[$];

    typedef struct {
        logic [3:0]  n;
        int          kind;
        int          gap_a;
        int          gap_b;
        int          hold;
        logic [19:0] exp;
    } vec_t;
    vec_t tbl[6];

    pe_mac_sequencer dut (
        .clk(clk), .rst(rst), .start(start), .num_taps(num_taps), .busy(busy),
        .in_valid(in_valid), .in_ready(in_ready), .in_ifm(in_ifm), .in_wgt(in_wgt),
        .pe_ifm(pe_ifm), .pe_wgt(pe_wgt), .pe_product(pe_product),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // PE stand-in: one-cycle registered multiplier.
    always @(posedge clk) pe_product <= 16'(pe_ifm) * 16'(pe_wgt);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Scoreboard: every accepted result is matched against the oldest expectation.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_result: got %0d expected none", out_data);
            end else begin
                check("result", out_data, exp_q.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "bench timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] p_ifm(input int kind, input int k);
        case (kind)
            1:       return 8'd255;
            2:       return 8'd7;
            default: return 8'(k + 1);
        endcase
    endfunction

    function automatic logic [7:0] p_wgt(input int kind, input int k);
        case (kind)
            0:       return 8'(k + 2);
            1:       return 8'd255;
            2:       return 8'd6;
            default: return 8'(k + 1);
        endcase
    endfunction

    task automatic send_pair(input logic [7:0] a, input logic [7:0] b);
        int t = 0;
        in_valid = 1'b1;
        in_ifm   = a;
        in_wgt   = b;
        @(negedge clk);
        while (!in_ready && t < 20) begin
            @(negedge clk);
            t++;
        end
        check("in_ready_for_pair", in_ready, 1);
        tick();
        last_acc = cyc;
        check("pe_ifm_issue", pe_ifm, a);
        check("pe_wgt_issue", pe_wgt, b);
    endtask

    task automatic wait_result(input int exp_lat);
        int t = 0;
        in_valid = 1'b0;
        @(negedge clk);
        check("in_ready_low_after_feed", in_ready, 0);
        while (!out_valid && t < 20) begin
            @(negedge clk);
            t++;
        end
        check("out_valid_seen", out_valid, 1);
        check("latency", cyc - last_acc, exp_lat);
    endtask

    task automatic run_vec(input vec_t t);
        int nf;
        nf = (t.n > 4'd9) ? 9 : int'(t.n);
        out_ready = (t.hold == 0);
        exp_q.push_back(t.exp);
        start    = 1'b1;
        num_taps = t.n;
        tick();
        start    = 1'b0;
        last_acc = cyc;
        for (int k = 0; k < nf; k++) begin
            send_pair(p_ifm(t.kind, k), p_wgt(t.kind, k));
            if (k + 1 == t.gap_a || k + 1 == t.gap_b) begin
                in_valid = 1'b0;
                repeat (2) begin
                    tick();
                    check("gap_pe_ifm", pe_ifm, 0);
                    check("gap_pe_wgt", pe_wgt, 0);
                end
            end
        end
        wait_result((t.n == 4'd0) ? 0 : 3);
        if (t.hold > 0) begin
            for (int h = 0; h < t.hold; h++) begin
                tick();
                num_taps = 4'd1;
                start    = 1'b1;
                @(negedge clk);
                check("hold_out_valid", out_valid, 1);
                check("hold_in_ready", in_ready, 0);
                check("hold_out_data", out_data, t.exp);
            end
            tick();
            out_ready = 1'b1;
            @(negedge clk);
            tick();
            start = 1'b0;
            @(negedge clk);
            check("start_ignored_busy", busy, 0);
            check("start_ignored_valid", out_valid, 0);
        end else begin
            @(negedge clk);
            check("pulse_1cycle", out_valid, 0);
            check("idle_after_result", busy, 0);
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; num_taps = '0; in_valid = 1'b0;
        in_ifm = '0; in_wgt = '0; out_ready = 1'b1;

        tbl[0] = '{n: 4'd8,  kind: 0, gap_a: 0, gap_b: 0, hold: 0, exp: 20'd240};
        tbl[1] = '{n: 4'd1,  kind: 2, gap_a: 0, gap_b: 0, hold: 0, exp: 20'd42};
        tbl[2] = '{n: 4'd8,  kind: 0, gap_a: 3, gap_b: 6, hold: 0, exp: 20'd240};
        tbl[3] = '{n: 4'd9,  kind: 1, gap_a: 0, gap_b: 0, hold: 5, exp: 20'd585225};
        tbl[4] = '{n: 4'd0,  kind: 0, gap_a: 0, gap_b: 0, hold: 0, exp: 20'd0};
        tbl[5] = '{n: 4'd12, kind: 3, gap_a: 0, gap_b: 0, hold: 0, exp: 20'd285};

        repeat (2) tick();
        @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_pe_ifm", pe_ifm, 0);
        tick();
        rst = 1'b0;
        tick();

        for (int v = 0; v < 6; v++) run_vec(tbl[v]);

        // Reset mid-window, then a fresh window must carry no residue.
        out_ready = 1'b1;
        start     = 1'b1;
        num_taps  = 4'd8;
        tick();
        start = 1'b0;
        for (int k = 0; k < 4; k++) send_pair(8'(k + 1), 8'(k + 2));
        rst      = 1'b1;
        in_valid = 1'b0;
        tick();
        check("midrst_busy", busy, 0);
        check("midrst_in_ready", in_ready, 0);
        check("midrst_out_valid", out_valid, 0);
        check("midrst_out_data", out_data, 0);
        check("midrst_pe_ifm", pe_ifm, 0);
        check("midrst_pe_wgt", pe_wgt, 0);
        rst = 1'b0;
        tick();
        exp_q.push_back(20'd112);
        start    = 1'b1;
        num_taps = 4'd2;
        tick();
        start = 1'b0;
        send_pair(8'd10, 8'd10);
        send_pair(8'd3, 8'd4);
        wait_result(3);
        @(negedge clk);
        check("post_rst_pulse", out_valid, 0);

        repeat (3) tick();
        check("scoreboard_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
